// File: rtl/baccarat_round_ctrl.sv
// Round sequencer for the baccarat datapath: clear, four-card deal, naturals,
// player/banker third-card rules and a one-cycle result strobe.
module baccarat_round_ctrl #(
  parameter int unsigned DEAL_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       reset_cards,
  output logic       load_wager,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic [1:0] result,
  output logic [1:0] winner,
  output logic       busy
);

  localparam int unsigned GAP_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_P1, S_D1, S_P2, S_D2, S_CHECK,
    S_P3, S_BDEC, S_D3, S_EVAL, S_RESULT, S_DONE, S_WAIT
  } state_t;

  state_t             state_q, state_d, ret_q, ret_d, deal_next;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               is_deal;
  logic               bank_draw;
  logic [3:0]         v;
  logic [1:0]         cmp;
  logic [1:0]         result_d, winner_d;

  // Banker third-card table, using the player's third card value (face cards count 0)
  always_comb begin
    v = (pcard3 <= 4'd9) ? pcard3 : 4'd0;
    unique case (dscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (v != 4'd8);
      4'd4:             bank_draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             bank_draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             bank_draw = (v >= 4'd6) && (v <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  always_comb begin
    if (pscore > dscore)      cmp = 2'b01;
    else if (dscore > pscore) cmp = 2'b10;
    else                      cmp = 2'b11;
  end

  // Next-state logic; deal states detour through WAIT when pacing is enabled
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    gap_d     = gap_q;
    is_deal   = 1'b0;
    deal_next = S_IDLE;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_P1;
      S_P1:     begin is_deal = 1'b1; deal_next = S_D1;   end
      S_D1:     begin is_deal = 1'b1; deal_next = S_P2;   end
      S_P2:     begin is_deal = 1'b1; deal_next = S_D2;   end
      S_D2:     begin is_deal = 1'b1; deal_next = S_CHECK; end
      S_P3:     begin is_deal = 1'b1; deal_next = S_BDEC; end
      S_D3:     begin is_deal = 1'b1; deal_next = S_EVAL; end
      S_CHECK: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = S_RESULT;
        else if (pscore <= 4'd5)              state_d = S_P3;
        else if (dscore <= 4'd5)              state_d = S_D3;
        else                                  state_d = S_RESULT;
      end
      S_BDEC:   state_d = bank_draw ? S_D3 : S_RESULT;
      S_EVAL:   state_d = S_RESULT;
      S_RESULT: state_d = S_DONE;
      S_WAIT: begin
        if (gap_q == '0) state_d = ret_q;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default:  state_d = S_IDLE;
    endcase
    if (is_deal) begin
      if (DEAL_GAP != 0) begin
        state_d = S_WAIT;
        ret_d   = deal_next;
        gap_d   = GAP_W'(DEAL_GAP - 1);
      end else begin
        state_d = deal_next;
      end
    end
  end

  always_comb begin
    result_d = (state_d == S_RESULT) ? cmp : 2'b00;
    winner_d = winner;
    if (state_d == S_CLEAR)  winner_d = 2'b00;
    if (state_d == S_RESULT) winner_d = cmp;
  end

  // Outputs are registered decodes of the next state, so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      gap_q       <= '0;
      reset_cards <= 1'b0;
      load_wager  <= 1'b0;
      load_pcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
      result      <= 2'b00;
      winner      <= 2'b00;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      gap_q       <= gap_d;
      reset_cards <= (state_d == S_CLEAR);
      load_wager  <= (state_d == S_CLEAR);
      load_pcard1 <= (state_d == S_P1);
      load_pcard2 <= (state_d == S_P2);
      load_pcard3 <= (state_d == S_P3);
      load_dcard1 <= (state_d == S_D1);
      load_dcard2 <= (state_d == S_D2);
      load_dcard3 <= (state_d == S_D3);
      result      <= result_d;
      winner      <= winner_d;
      busy        <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench: a cycle-level expectation of each round is built from the
// baccarat rules and compared against two instances (no pacing and DEAL_GAP=3).
module tb_baccarat_round_ctrl;

  typedef struct {
    logic [3:0] p0, d0, c3, p1, d1;
  } scen_t;

  logic       clk = 1'b0;
  logic       rst0, rst3, start0, start3;
  logic [3:0] pcard3, pscore, dscore;
  logic       sel3;

  logic       rc0, lw0, lp10, lp20, lp30, ld10, ld20, ld30, busy0;
  logic [1:0] res0, win0;
  logic       rc3, lw3, lp13, lp23, lp33, ld13, ld23, ld33, busy3;
  logic [1:0] res3, win3;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  baccarat_round_ctrl #(.DEAL_GAP(0)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .pcard3(pcard3), .pscore(pscore), .dscore(dscore),
    .reset_cards(rc0), .load_wager(lw0), .load_pcard1(lp10), .load_pcard2(lp20), .load_pcard3(lp30),
    .load_dcard1(ld10), .load_dcard2(ld20), .load_dcard3(ld30), .result(res0), .winner(win0), .busy(busy0));

  baccarat_round_ctrl #(.DEAL_GAP(3)) dut3 (
    .clk(clk), .reset(rst3), .start(start3), .pcard3(pcard3), .pscore(pscore), .dscore(dscore),
    .reset_cards(rc3), .load_wager(lw3), .load_pcard1(lp13), .load_pcard2(lp23), .load_pcard3(lp33),
    .load_dcard1(ld13), .load_dcard2(ld23), .load_dcard3(ld33), .result(res3), .winner(win3), .busy(busy3));

  // {busy, winner, result, reset_cards, load_wager, p1, d1, p2, d2, p3, d3}
  wire [12:0] obs0 = {busy0, win0, res0, rc0, lw0, lp10, ld10, lp20, ld20, lp30, ld30};
  wire [12:0] obs3 = {busy3, win3, res3, rc3, lw3, lp13, ld13, lp23, ld23, lp33, ld33};
  wire [12:0] obs  = sel3 ? obs3 : obs0;

  task automatic check(input string tag, input int cyc, input logic [12:0] o, input logic [12:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic deal(input logic [7:0] strobe, input int gap);
    exp_q.push_back({1'b1, 2'b00, 2'b00, strobe});
    for (int k = 0; k < gap; k++) exp_q.push_back({1'b1, 4'b0, 8'b0});
  endtask

  // Reference: the whole round as a list of per-cycle output vectors
  task automatic build(input scen_t s, input int gap);
    bit natural, pdraw, ddraw;
    int v, pf, df;
    logic [1:0] r;
    exp_q.delete();
    exp_q.push_back({1'b1, 4'b0, 8'b1100_0000});
    deal(8'b0010_0000, gap);
    deal(8'b0001_0000, gap);
    deal(8'b0000_1000, gap);
    deal(8'b0000_0100, gap);
    exp_q.push_back({1'b1, 4'b0, 8'b0});
    natural = (s.p0 >= 8) || (s.d0 >= 8);
    pdraw   = !natural && (s.p0 <= 5);
    ddraw   = 0;
    if (pdraw) begin
      deal(8'b0000_0010, gap);
      exp_q.push_back({1'b1, 4'b0, 8'b0});
      v = (s.c3 <= 9) ? int'(s.c3) : 0;
      case (s.d0)
        0, 1, 2: ddraw = 1;
        3:       ddraw = (v != 8);
        4:       ddraw = (v >= 2 && v <= 7);
        5:       ddraw = (v >= 4 && v <= 7);
        6:       ddraw = (v == 6 || v == 7);
        default: ddraw = 0;
      endcase
    end else if (!natural) begin
      ddraw = (s.d0 <= 5);
    end
    if (ddraw) begin
      deal(8'b0000_0001, gap);
      exp_q.push_back({1'b1, 4'b0, 8'b0});
    end
    pf = pdraw ? int'(s.p1) : int'(s.p0);
    df = ddraw ? int'(s.d1) : int'(s.d0);
    r  = (pf > df) ? 2'b01 : (df > pf) ? 2'b10 : 2'b11;
    exp_q.push_back({1'b1, r, r, 8'b0});
    exp_q.push_back({1'b0, r, 2'b00, 8'b0});
  endtask

  // Datapath stand-in: score inputs follow the load strobes it is given
  task automatic datapath(input scen_t s, input logic [12:0] o);
    if (o[7]) begin pcard3 = 4'd0; pscore = 4'd0; dscore = 4'd0; end
    if (o[2]) begin pscore = s.p0; dscore = s.d0; end
    if (o[1]) begin pcard3 = s.c3; pscore = s.p1; end
    if (o[0]) dscore = s.d1;
  endtask

  task automatic run_round(input string tag, input scen_t s, input bit use3, input bit glitch);
    sel3 = use3;
    build(s, use3 ? 3 : 0);
    @(negedge clk);
    if (use3) start3 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      start0 = 1'b0;
      check(tag, i + 1, obs, exp_q[i]);
      datapath(s, obs);
      if (glitch && i == 2) start0 = 1'b1;
    end
  endtask

  function automatic scen_t mk(input int p0, d0, c3, p1, d1);
    scen_t s;
    s.p0 = 4'(p0); s.d0 = 4'(d0); s.c3 = 4'(c3); s.p1 = 4'(p1); s.d1 = 4'(d1);
    return s;
  endfunction

  initial begin
    scen_t s;
    rst0 = 1'b1; rst3 = 1'b1; start0 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
    pcard3 = 4'd0; pscore = 4'd0; dscore = 4'd0;
    repeat (3) @(negedge clk);
    check("reset0", 0, obs0, 13'b0);
    check("reset3", 0, obs3, 13'b0);
    rst0 = 1'b0; rst3 = 1'b0;

    run_round("natural", mk(8, 3, 0, 0, 0), 0, 0);
    run_round("both_draw", mk(5, 3, 13, 5, 4), 0, 0);
    run_round("bank_stand_v8", mk(2, 3, 8, 0, 0), 0, 0);
    run_round("tie_d7", mk(2, 7, 8, 7, 0), 0, 0);
    run_round("pstand_tie", mk(6, 5, 0, 0, 6), 0, 0);
    run_round("pstand_dwin", mk(6, 5, 0, 0, 9), 0, 1);
    run_round("both_stand", mk(7, 6, 0, 0, 0), 0, 0);
    run_round("over9", mk(12, 2, 0, 0, 0), 0, 0);

    // Abort during D1: outputs drop to zero and no result follows
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_d1", 3, obs0, {1'b1, 4'b0, 8'b0001_0000});
    rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    check("abort", 4, obs0, 13'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", 5, obs0, 13'b0);
    end

    for (int n = 0; n < 20; n++) begin
      s.p0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      s.d0 = 4'($urandom_range(0, 9));
      s.c3 = 4'($urandom_range(1, 13));
      s.p1 = 4'($urandom_range(0, 9));
      s.d1 = 4'($urandom_range(0, 9));
      run_round("rand0", s, 0, n[0]);
    end

    run_round("gap3_natural", mk(9, 1, 0, 0, 0), 1, 0);
    for (int n = 0; n < 6; n++) begin
      s.p0 = 4'($urandom_range(0, 9));
      s.d0 = 4'($urandom_range(0, 9));
      s.c3 = 4'($urandom_range(1, 13));
      s.p1 = 4'($urandom_range(0, 9));
      s.d1 = 4'($urandom_range(0, 9));
      run_round("rand3", s, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
